fft_r2_stage_pipe: RTL and testbench

Parametrised, pipelined radix-2 butterfly stage for the streaming FFT datapath. It applies one rank of butterflies with trivial twiddles (1 and ∓j) to a full frame of NPT complex samples per beat. It adds a valid/ready handshake, a selectable forward/inverse twiddle, optional divide-by-2 scaling and saturating arithmetic with a sticky overflow flag. It slots in wherever a combinational trivial-twiddle stage would otherwise sit between pipeline registers.

---
 rtl/fft_r2_stage_pipe_if.sv | 35 +++
 rtl/fft_r2_stage_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_fft_r2_stage_pipe.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_r2_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// fft_r2_stage_pipe_if
// Bundles the streaming handshake, frame buses, per-beat control bits and
// the sticky saturation flag of one fft_r2_stage_pipe instance.
//   in_valid/in_ready/in_data/in_inv/in_scale : upstream beat and its controls
//   out_valid/out_ready/out_data              : downstream beat
//   sat_flag/sat_clr                          : sticky saturation status / clear
// master : the side that feeds frames in and drains results (upstream+downstream)
// slave  : the butterfly stage itself
// ---------------------------------------------------------------------------
interface fft_r2_stage_pipe_if #(
  parameter int DW  = 16,
  parameter int NPT = 16
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [NPT*2*DW-1:0]   in_data;
  logic                  in_inv;
  logic                  in_scale;
  logic                  out_valid;
  logic                  out_ready;
  logic [NPT*2*DW-1:0]   out_data;
  logic                  sat_flag;
  logic                  sat_clr;

  modport master (
    output in_valid, in_data, in_inv, in_scale, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_scale, out_ready, sat_clr,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/fft_r2_stage_pipe.sv
// ---------------------------------------------------------------------------
// fft_r2_stage_pipe
// One rank of radix-2 butterflies with trivial twiddles (1, -j / +j) over a
// full frame of NPT complex samples per beat, wrapped in an elastic
// valid/ready register chain of PIPE stages (1 or 2).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (drops every in-flight beat)
//   bus  : fft_r2_stage_pipe_if.slave (handshakes, frames, inv/scale, sat flag)
// Parameters: DW component width, NPT samples per frame, SPAN butterfly
// distance (1 or 2), PIPE register stages (2 adds a raw input register).
// ---------------------------------------------------------------------------
module fft_r2_stage_pipe #(
  parameter int DW   = 16,
  parameter int NPT  = 16,
  parameter int SPAN = 2,
  parameter int PIPE = 1
) (
  input logic                clk,
  input logic                rst,
  fft_r2_stage_pipe_if.slave bus
);

  localparam int FW  = NPT * 2 * DW;   // frame width
  localparam int SW  = 2 * DW;         // one complex sample
  localparam int GRP = 2 * SPAN;       // samples per butterfly group
  localparam int EW  = DW + 2;         // headroom: sum/diff plus exact negation

  localparam logic signed [EW-1:0] RND_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

  // Sign-extend one component into the working width.
  function automatic logic signed [EW-1:0] sext(input logic [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  // Optional round-half-up halving, then clamp; returns {saturated, value}.
  function automatic logic [DW:0] scale_sat(input logic signed [EW-1:0] v,
                                            input logic              scale);
    logic signed [EW-1:0] t;
    logic [DW:0]          r;
    if (scale) begin
      t = (v + RND_ONE) >>> 1'b1;
    end else begin
      t = v;
    end
    if (t > SAT_MAX) begin
      r = {1'b1, SAT_MAX[DW-1:0]};
    end else if (t < SAT_MIN) begin
      r = {1'b1, SAT_MIN[DW-1:0]};
    end else begin
      r = {1'b0, t[DW-1:0]};
    end
    return r;
  endfunction

  // Beat presented to the arithmetic / output register
  logic          src_valid_s;
  logic [FW-1:0] src_data_s;
  logic          src_inv_s;
  logic          src_scale_s;
  logic          in_ready_s;

  logic [FW-1:0] res_data_s;
  logic          res_sat_s;

  logic          out_valid_q, out_valid_d;
  logic [FW-1:0] out_data_q,  out_data_d;
  logic          sat_q,       sat_d;
  logic          out_take_s;

  // Output register can accept: empty, or its beat is drained this cycle.
  assign out_take_s = ~out_valid_q | bus.out_ready;

  generate
    if (PIPE == 2) begin : g_in_reg
      logic          in_valid_q, in_valid_d;
      logic [FW-1:0] in_data_q,  in_data_d;
      logic          in_inv_q,   in_inv_d;
      logic          in_scale_q, in_scale_d;
      logic          in_load_s;

      assign in_ready_s = ~rst & (~in_valid_q | out_take_s);
      assign in_load_s  = bus.in_valid & in_ready_s;

      // Input register next state: refill when empty or handing off downstream.
      always_comb begin
        in_valid_d = in_valid_q;
        in_data_d  = in_data_q;
        in_inv_d   = in_inv_q;
        in_scale_d = in_scale_q;
        if (~in_valid_q | out_take_s) begin
          in_valid_d = in_load_s;
          if (in_load_s) begin
            in_data_d  = bus.in_data;
            in_inv_d   = bus.in_inv;
            in_scale_d = bus.in_scale;
          end else begin
            in_data_d  = in_data_q;
          end
        end else begin
          in_valid_d = in_valid_q;
        end
      end

      // Input register state.
      always_ff @(posedge clk) begin
        if (rst) begin
          in_valid_q <= 1'b0;
          in_data_q  <= '0;
          in_inv_q   <= 1'b0;
          in_scale_q <= 1'b0;
        end else begin
          in_valid_q <= in_valid_d;
          in_data_q  <= in_data_d;
          in_inv_q   <= in_inv_d;
          in_scale_q <= in_scale_d;
        end
      end

      assign src_valid_s = in_valid_q;
      assign src_data_s  = in_data_q;
      assign src_inv_s   = in_inv_q;
      assign src_scale_s = in_scale_q;
    end else begin : g_no_in_reg
      assign in_ready_s  = ~rst & out_take_s;
      assign src_valid_s = bus.in_valid;
      assign src_data_s  = bus.in_data;
      assign src_inv_s   = bus.in_inv;
      assign src_scale_s = bus.in_scale;
    end
  endgenerate

  // Butterfly rank: pair m maps to lower index i and partner i+SPAN.
  always_comb begin
    logic signed [EW-1:0] ar, ai, br, bi, sr, si, dr, di, tr, ti;
    logic [DW:0]          q;
    int                   i;
    int                   p;
    ar = '0; ai = '0; br = '0; bi = '0;
    sr = '0; si = '0; dr = '0; di = '0;
    tr = '0; ti = '0; q = '0; i = 0; p = 0;
    res_data_s = '0;
    res_sat_s  = 1'b0;
    for (int m = 0; m < NPT / 2; m++) begin
      i  = (m / SPAN) * GRP + (m % SPAN);
      p  = i + SPAN;
      ar = sext(src_data_s[SW*i+DW +: DW]);
      ai = sext(src_data_s[SW*i    +: DW]);
      br = sext(src_data_s[SW*p+DW +: DW]);
      bi = sext(src_data_s[SW*p    +: DW]);
      sr = ar + br;
      si = ai + bi;
      dr = ar - br;
      di = ai - bi;
      // Offset 0 passes the difference through; offset 1 rotates by -j or +j.
      if ((m % SPAN) == 32'sd0) begin
        tr = dr;
        ti = di;
      end else if (src_inv_s) begin
        tr = -di;
        ti = dr;
      end else begin
        tr = di;
        ti = -dr;
      end
      q = scale_sat(sr, src_scale_s);
      res_data_s[SW*i+DW +: DW] = q[DW-1:0];
      res_sat_s = res_sat_s | q[DW];
      q = scale_sat(si, src_scale_s);
      res_data_s[SW*i +: DW] = q[DW-1:0];
      res_sat_s = res_sat_s | q[DW];
      q = scale_sat(tr, src_scale_s);
      res_data_s[SW*p+DW +: DW] = q[DW-1:0];
      res_sat_s = res_sat_s | q[DW];
      q = scale_sat(ti, src_scale_s);
      res_data_s[SW*p +: DW] = q[DW-1:0];
      res_sat_s = res_sat_s | q[DW];
    end
  end

  // Output register and sticky flag next state; a clear loses to a same-cycle set.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sat_d       = sat_q & ~bus.sat_clr;
    if (out_take_s) begin
      out_valid_d = src_valid_s;
      if (src_valid_s) begin
        out_data_d = res_data_s;
        sat_d      = sat_d | res_sat_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_fft_r2_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_fft_r2_stage_pipe
// Directed checks of fft_r2_stage_pipe: arithmetic (forward/inverse, scaling,
// saturation, sticky flag) on a PIPE=1 instance, backpressure and mid-stream
// reset on a PIPE=2 instance, and a SPAN=1 NPT=8 instance against an
// integer reference with random valid/ready.
// ---------------------------------------------------------------------------
module tb_fft_r2_stage_pipe;

  typedef logic [511:0] val_t;

  logic clk;
  logic rst;

  int n_vec;
  int n_bad;

  fft_r2_stage_pipe_if #(.DW(16), .NPT(16)) bus_a ();
  fft_r2_stage_pipe_if #(.DW(16), .NPT(16)) bus_b ();
  fft_r2_stage_pipe_if #(.DW(8),  .NPT(8))  bus_c ();

  fft_r2_stage_pipe #(.DW(16), .NPT(16), .SPAN(2), .PIPE(1)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  fft_r2_stage_pipe #(.DW(16), .NPT(16), .SPAN(2), .PIPE(2)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  fft_r2_stage_pipe #(.DW(8),  .NPT(8),  .SPAN(1), .PIPE(2)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input val_t act, input val_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic val_t put(input val_t f, input int i,
                               input logic [15:0] re, input logic [15:0] im);
    f[32*i +: 32] = {re, im};
    return f;
  endfunction

  // One beat into the PIPE=1 instance; result is in the output register on return.
  task automatic drive_a(input val_t f, input logic inv, input logic sc, input logic clr);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = f[511:0];
    bus_a.in_inv   = inv;
    bus_a.in_scale = sc;
    bus_a.sat_clr  = clr;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.sat_clr  = 1'b0;
  endtask

  function automatic int clamp8(input int v, input logic sc);
    int t;
    t = v;
    if (sc) t = (t + 1) >>> 1;
    if (t > 127) t = 127;
    else if (t < -128) t = -128;
    return t;
  endfunction

  // SPAN=1 reference: out[2m] = x[2m]+x[2m+1], out[2m+1] = x[2m]-x[2m+1].
  function automatic logic [127:0] model_c(input logic [127:0] x, input logic sc);
    logic [127:0] r;
    int ar, ai, br, bi;
    r = '0;
    for (int m = 0; m < 4; m++) begin
      ar = int'($signed(x[16*(2*m)+8   +: 8]));
      ai = int'($signed(x[16*(2*m)     +: 8]));
      br = int'($signed(x[16*(2*m+1)+8 +: 8]));
      bi = int'($signed(x[16*(2*m+1)   +: 8]));
      r[16*(2*m)+8   +: 8] = 8'(clamp8(ar + br, sc));
      r[16*(2*m)     +: 8] = 8'(clamp8(ai + bi, sc));
      r[16*(2*m+1)+8 +: 8] = 8'(clamp8(ar - br, sc));
      r[16*(2*m+1)   +: 8] = 8'(clamp8(ai - bi, sc));
    end
    return r;
  endfunction

  val_t f, e, g, h, eg, eh;
  val_t beats [3];
  val_t expb  [3];
  logic [127:0] q_c [$];
  logic [127:0] exp_c;
  int   acc;
  logic stale;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_inv = 1'b0; bus_a.in_scale = 1'b0;
    bus_a.out_ready = 1'b1; bus_a.sat_clr = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_inv = 1'b0; bus_b.in_scale = 1'b0;
    bus_b.out_ready = 1'b1; bus_b.sat_clr = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.in_inv = 1'b0; bus_c.in_scale = 1'b0;
    bus_c.out_ready = 1'b1; bus_c.sat_clr = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    check_eq("rst_in_ready",  val_t'(bus_a.in_ready),  val_t'(1'b0));
    check_eq("rst_out_valid", val_t'(bus_a.out_valid), val_t'(1'b0));
    check_eq("rst_out_data",  val_t'(bus_a.out_data),  val_t'(1'b0));
    check_eq("rst_sat_flag",  val_t'(bus_a.sat_flag),  val_t'(1'b0));
    check_eq("rst_b_in_ready", val_t'(bus_b.in_ready), val_t'(1'b0));
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready",   val_t'(bus_a.in_ready), val_t'(1'b1));
    check_eq("rel_b_in_ready", val_t'(bus_b.in_ready), val_t'(1'b1));

    // ---- forward / inverse, SPAN=2 PIPE=1 ----
    f = '0;
    f = put(f, 0, 16'h0100, 16'h0200);
    f = put(f, 2, 16'h0050, 16'h0010);
    f = put(f, 1, 16'h0300, 16'h0100);
    f = put(f, 3, 16'h0100, 16'h0040);
    e = '0;
    e = put(e, 0, 16'h0150, 16'h0210);
    e = put(e, 2, 16'h00B0, 16'h01F0);
    e = put(e, 1, 16'h0400, 16'h0140);
    e = put(e, 3, 16'h00C0, 16'hFE00);
    drive_a(f, 1'b0, 1'b0, 1'b0);
    check_eq("fwd_valid", val_t'(bus_a.out_valid), val_t'(1'b1));
    check_eq("fwd_data",  val_t'(bus_a.out_data),  e);
    check_eq("fwd_sat",   val_t'(bus_a.sat_flag),  val_t'(1'b0));
    tick();
    check_eq("fwd_single", val_t'(bus_a.out_valid), val_t'(1'b0));

    drive_a(f, 1'b1, 1'b0, 1'b0);
    check_eq("inv_data", val_t'(bus_a.out_data), put(e, 3, 16'hFF40, 16'h0200));

    // ---- saturation, sticky flag, scaling ----
    g = '0;
    g = put(g, 0, 16'h7000, 16'h0000);
    g = put(g, 2, 16'h2000, 16'h0000);
    eg = '0;
    eg = put(eg, 0, 16'h7FFF, 16'h0000);
    eg = put(eg, 2, 16'h5000, 16'h0000);
    drive_a(g, 1'b0, 1'b0, 1'b0);
    check_eq("sat_data", val_t'(bus_a.out_data), eg);
    check_eq("sat_flag", val_t'(bus_a.sat_flag), val_t'(1'b1));
    tick();
    check_eq("sat_sticky", val_t'(bus_a.sat_flag), val_t'(1'b1));
    bus_a.sat_clr = 1'b1;
    tick();
    bus_a.sat_clr = 1'b0;
    check_eq("sat_clr", val_t'(bus_a.sat_flag), val_t'(1'b0));

    eg = '0;
    eg = put(eg, 0, 16'h4800, 16'h0000);
    eg = put(eg, 2, 16'h2800, 16'h0000);
    drive_a(g, 1'b0, 1'b1, 1'b0);
    check_eq("scale_data", val_t'(bus_a.out_data), eg);
    check_eq("scale_nosat", val_t'(bus_a.sat_flag), val_t'(1'b0));

    h = '0;
    h = put(h, 1, 16'h8000, 16'h0000);
    h = put(h, 3, 16'h7FFF, 16'h0000);
    eh = '0;
    eh = put(eh, 1, 16'hFFFF, 16'h0000);
    eh = put(eh, 3, 16'h0000, 16'h7FFF);
    drive_a(h, 1'b0, 1'b0, 1'b0);
    check_eq("neg_min_data", val_t'(bus_a.out_data), eh);
    check_eq("neg_min_sat",  val_t'(bus_a.sat_flag), val_t'(1'b1));
    bus_a.sat_clr = 1'b1;
    tick();
    bus_a.sat_clr = 1'b0;
    check_eq("clr_again", val_t'(bus_a.sat_flag), val_t'(1'b0));
    drive_a(h, 1'b0, 1'b0, 1'b1);
    check_eq("clr_vs_set", val_t'(bus_a.sat_flag), val_t'(1'b1));
    bus_a.sat_clr = 1'b1;
    tick();
    bus_a.sat_clr = 1'b0;
    check_eq("clr_alone", val_t'(bus_a.sat_flag), val_t'(1'b0));

    // back-to-back beats, controls per beat
    bus_a.in_valid = 1'b1; bus_a.in_data = f; bus_a.in_inv = 1'b1; bus_a.in_scale = 1'b0;
    tick();
    bus_a.in_data = g; bus_a.in_inv = 1'b0; bus_a.in_scale = 1'b1;
    check_eq("b2b_first", val_t'(bus_a.out_data), put(e, 3, 16'hFF40, 16'h0200));
    tick();
    bus_a.in_valid = 1'b0; bus_a.in_scale = 1'b0;
    check_eq("b2b_second", val_t'(bus_a.out_data), eg);

    // ---- backpressure, PIPE=2 ----
    beats[0] = put(put('0, 0, 16'h0001, 16'h0002), 2, 16'h0003, 16'h0004);
    expb[0]  = put(put('0, 0, 16'h0004, 16'h0006), 2, 16'hFFFE, 16'hFFFE);
    beats[1] = put(put('0, 0, 16'h0010, 16'h0000), 2, 16'h0000, 16'h0010);
    expb[1]  = put(put('0, 0, 16'h0010, 16'h0010), 2, 16'h0010, 16'hFFF0);
    beats[2] = put('0, 1, 16'h0020, 16'h0000);
    expb[2]  = put(put('0, 1, 16'h0020, 16'h0000), 3, 16'h0000, 16'hFFE0);
    bus_b.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = beats[acc];
      #1;
      if (bus_b.in_ready) acc++;
      tick();
    end
    check_eq("bp_accepted",  val_t'(acc),             val_t'(2));
    check_eq("bp_in_ready",  val_t'(bus_b.in_ready),  val_t'(1'b0));
    check_eq("bp_out_valid", val_t'(bus_b.out_valid), val_t'(1'b1));
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_hold_data", val_t'(bus_b.out_data), expb[0]);
      tick();
    end
    bus_b.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", val_t'(bus_b.in_ready), val_t'(1'b1));
    tick();
    bus_b.in_valid = 1'b0;
    check_eq("bp_beat1", val_t'(bus_b.out_data), expb[1]);
    tick();
    check_eq("bp_beat2_valid", val_t'(bus_b.out_valid), val_t'(1'b1));
    check_eq("bp_beat2", val_t'(bus_b.out_data), expb[2]);
    tick();
    check_eq("bp_drained", val_t'(bus_b.out_valid), val_t'(1'b0));

    // ---- reset with two beats in flight ----
    bus_b.out_ready = 1'b0;
    bus_b.in_valid = 1'b1; bus_b.in_data = beats[0];
    tick();
    bus_b.in_data = beats[1];
    tick();
    bus_b.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("mrst_out_valid", val_t'(bus_b.out_valid), val_t'(1'b0));
    check_eq("mrst_out_data",  val_t'(bus_b.out_data),  val_t'(1'b0));
    check_eq("mrst_in_ready",  val_t'(bus_b.in_ready),  val_t'(1'b0));
    rst = 1'b0;
    bus_b.out_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      stale = stale | bus_b.out_valid;
    end
    check_eq("mrst_no_stale", val_t'(stale), val_t'(1'b0));

    // ---- SPAN=1 NPT=8 DW=8 against the reference, random valid/ready ----
    for (int c = 0; c < 3000; c++) begin
      bus_c.in_valid  = 1'($urandom_range(0, 1));
      bus_c.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_c.in_inv    = 1'($urandom_range(0, 1));
      bus_c.in_scale  = 1'($urandom_range(0, 1));
      bus_c.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus_c.out_valid && bus_c.out_ready) begin
        if (q_c.size() == 0) begin
          check_eq("c_spurious", val_t'(1'b1), val_t'(1'b0));
        end else begin
          exp_c = q_c.pop_front();
          check_eq("c_frame", val_t'(bus_c.out_data), val_t'(exp_c));
        end
      end
      if (bus_c.in_valid && bus_c.in_ready) begin
        q_c.push_back(model_c(bus_c.in_data, bus_c.in_scale));
      end
      tick();
    end
    bus_c.in_valid  = 1'b0;
    bus_c.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus_c.out_valid) begin
        if (q_c.size() == 0) begin
          check_eq("c_drain_spurious", val_t'(1'b1), val_t'(1'b0));
        end else begin
          exp_c = q_c.pop_front();
          check_eq("c_drain_frame", val_t'(bus_c.out_data), val_t'(exp_c));
        end
      end
      tick();
    end
    check_eq("c_drain_empty", val_t'(q_c.size()), val_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
